// File: rtl/commit_rx_if.sv
// Retirement channel carrying one committed-instruction record per valid cycle; no backpressure.
interface commit_if;
  logic        valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        trap;
  logic [1:0]  priv;

  modport mon (input valid, pc, instr, rd_addr, rd_data, mem_we, mem_addr, mem_wdata, trap, priv);
  modport drv (output valid, pc, instr, rd_addr, rd_data, mem_we, mem_addr, mem_wdata, trap, priv);
endinterface

// File: rtl/commit_rx.sv
// Commit monitor: shadow RF, record FIFO (1-cycle push-to-head, drops when full without pop), inactivity FSM.
// Optional pc sequence checker enabled by `define COMMIT_RX_PC_CHECK_EN.
module commit_rx #(
  parameter int DEPTH        = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  commit_if.mon       cmt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  out_rd_addr,
  output logic [63:0] out_rd_data,
  output logic        out_trap,
  input  logic [4:0]  rf_raddr,
  output logic [63:0] rf_rdata,
  output logic [31:0] commit_cnt,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  output logic        done,
  output logic        late_commit,
  output logic        pc_err,
  output logic [63:0] err_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        trap;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push;
  logic          rf_we;
  logic [63:0]   rf [32];
  logic [1:0]    state;
  logic [CW-1:0] idle_cnt;
  logic          unused_fields;

  assign unused_fields = ^{cmt.mem_we, cmt.mem_addr, cmt.mem_wdata, cmt.priv};

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push      = cmt.valid && (!full || pop);

  assign head        = mem[rd_ptr];
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_rd_addr = head.rd_addr;
  assign out_rd_data = head.rd_data;
  assign out_trap    = head.trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: cmt.pc, instr: cmt.instr, rd_addr: cmt.rd_addr,
                         rd_data: cmt.rd_data, trap: cmt.trap};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // x0 is never written, so the RF entry itself stays zero.
  assign rf_we = cmt.valid && !cmt.trap && (cmt.rd_addr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf_rdata <= '0;
    end else begin
      if (rf_we) rf[cmt.rd_addr] <= cmt.rd_data;
      rf_rdata <= (rf_we && cmt.rd_addr == rf_raddr) ? cmt.rd_data : rf[rf_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (cmt.valid) begin
      commit_cnt <= commit_cnt + 32'd1;
      if (!push) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idle_cnt    <= '0;
      late_commit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmt.valid) begin
          state    <= S_ACTIVE;
          idle_cnt <= '0;
        end
        S_ACTIVE: if (cmt.valid) begin
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
          if (idle_cnt == CW'(IDLE_TIMEOUT - 1)) state <= S_DONE;
        end
        S_DONE: if (cmt.valid) begin
          late_commit <= 1'b1;
          state       <= S_ACTIVE;
          idle_cnt    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done = (state == S_DONE);

`ifdef COMMIT_RX_PC_CHECK_EN
  logic [63:0] prev_pc;
  logic        prev_exempt, have_prev, viol;
  logic [6:0]  opc;

  assign opc  = cmt.instr[6:0];
  assign viol = cmt.valid && ((cmt.pc[1:0] != 2'b00) ||
                (have_prev && !prev_exempt && cmt.pc != prev_pc + 64'd4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc     <= '0;
      prev_exempt <= 1'b0;
      have_prev   <= 1'b0;
      pc_err      <= 1'b0;
      err_pc      <= '0;
    end else begin
      if (cmt.valid) begin
        prev_pc     <= cmt.pc;
        prev_exempt <= cmt.trap || opc == 7'b1101111 || opc == 7'b1100111 || opc == 7'b1100011;
        have_prev   <= 1'b1;
      end
      if (viol && !pc_err) begin
        pc_err <= 1'b1;
        err_pc <= cmt.pc;
      end
    end
  end
`else
  assign pc_err = 1'b0;
  assign err_pc = '0;
`endif

endmodule

// File: tb/tb_commit_rx.sv
// Directed bench for commit_rx: vector table for the basic flow, hand sequences for the corner cases.
module tb_commit_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_rd_data, rf_rdata, err_pc;
  logic [31:0] out_instr, commit_cnt;
  logic [4:0]  out_rd_addr, rf_raddr;
  logic        out_trap, overflow, done, late_commit, pc_err;
  logic [15:0] drop_cnt;

  int nchk = 0;
  int nerr = 0;

`ifdef COMMIT_RX_PC_CHECK_EN
  localparam logic PCCHK = 1'b1;
`else
  localparam logic PCCHK = 1'b0;
`endif

  commit_if cmt();

  commit_rx #(.DEPTH(8), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmt(cmt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data), .out_trap(out_trap),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .done(done), .late_commit(late_commit), .pc_err(pc_err), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [4:0]  raddr;
    logic        exp_ov;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    logic [63:0] exp_rf;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [63:0] data, input logic trap);
    cmt.valid = 1'b1; cmt.pc = pc; cmt.instr = instr; cmt.rd_addr = rd;
    cmt.rd_data = data; cmt.trap = trap;
    cyc();
    cmt.valid = 1'b0;
  endtask

  task automatic do_reset();
    cmt.valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [63:0] last, pc;

    cmt.valid = 1'b0; cmt.pc = '0; cmt.instr = '0; cmt.rd_addr = '0; cmt.rd_data = '0;
    cmt.mem_we = 1'b0; cmt.mem_addr = '0; cmt.mem_wdata = '0; cmt.trap = 1'b0; cmt.priv = 2'd3;
    out_ready = 1'b0;
    rf_raddr = '0;

    tbl[0] = '{1'b1, 64'h1000, 32'h01300093, 5'd1, 64'd19, 5'd0, 1'b1, 64'h1000, 32'h01300093, 64'd0,  32'd1};
    tbl[1] = '{1'b1, 64'h1004, 32'h01400113, 5'd2, 64'd20, 5'd1, 1'b1, 64'h1004, 32'h01400113, 64'd19, 32'd2};
    tbl[2] = '{1'b1, 64'h1008, 32'h01500193, 5'd3, 64'd21, 5'd3, 1'b1, 64'h1008, 32'h01500193, 64'd21, 32'd3};
    tbl[3] = '{1'b0, 64'h0,    32'h0,        5'd0, 64'd0,  5'd2, 1'b0, 64'h0,    32'h0,        64'd20, 32'd3};

    cyc();
    chk("rst out_valid", out_valid, 0);
    chk("rst out_pc", out_pc, 0);
    chk("rst out_rd_data", out_rd_data, 0);
    chk("rst rf_rdata", rf_rdata, 0);
    chk("rst commit_cnt", commit_cnt, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst flags", {overflow, done, late_commit, pc_err}, 0);
    chk("rst err_pc", err_pc, 0);
    rst_n = 1'b1;

    // Three addi commits with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmt.valid = tbl[i].v; cmt.pc = tbl[i].pc; cmt.instr = tbl[i].instr;
      cmt.rd_addr = tbl[i].rd; cmt.rd_data = tbl[i].data; cmt.trap = 1'b0;
      rf_raddr = tbl[i].raddr;
      cyc();
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d out_instr", i), out_instr, tbl[i].exp_instr);
        chk($sformatf("vec%0d out_rd_data", i), out_rd_data, tbl[i].data);
      end
      chk($sformatf("vec%0d rf_rdata", i), rf_rdata, tbl[i].exp_rf);
      chk($sformatf("vec%0d commit_cnt", i), commit_cnt, tbl[i].exp_cnt);
    end
    cmt.valid = 1'b0;

    // Last commit was at the vec2 edge; done must rise exactly 16 edges later.
    for (int k = 2; k <= 15; k++) cyc();
    chk("done before timeout", done, 0);
    cyc();
    chk("done at timeout", done, 1);
    chk("late_commit clear", late_commit, 0);

    commit(64'h100C, 32'h00000013, 5'd0, 64'd0, 1'b0);
    chk("late done cleared", done, 0);
    chk("late_commit set", late_commit, 1);
    chk("late commit_cnt", commit_cnt, 4);
    chk("no pc_err in order", pc_err, 0);
    for (int k = 1; k <= 15; k++) cyc();
    chk("rearmed done low", done, 0);
    cyc();
    chk("rearmed done high", done, 1);

    // x0 and trapping writes never reach the RF.
    do_reset();
    commit(64'h2000, 32'h00500013, 5'd0, 64'd5, 1'b0);
    commit(64'h2004, 32'h00700213, 5'd4, 64'd7, 1'b1);
    rf_raddr = 5'd4;
    cyc();
    chk("trap x4", rf_rdata, 0);
    rf_raddr = 5'd0;
    cyc();
    chk("x0 read", rf_rdata, 0);
    chk("rd0/trap commit_cnt", commit_cnt, 2);

    // Overflow: 10 commits into an 8-deep FIFO with no consumer.
    do_reset();
    pc = 64'h3000;
    for (int i = 0; i < 10; i++) begin
      commit(pc, 32'h00000013, 5'd5, 64'(i), 1'b0);
      pc += 4;
    end
    chk("ovf overflow", overflow, 1);
    chk("ovf drop_cnt", drop_cnt, 2);
    chk("ovf commit_cnt", commit_cnt, 10);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d valid", i), out_valid, 1);
      chk($sformatf("drain%0d pc", i), out_pc, 64'h3000 + 64'(4 * i));
      cyc();
    end
    chk("drained empty", out_valid, 0);

    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      commit(pc, 32'h00000013, 5'd5, 64'd0, 1'b0);
      pc += 4;
    end
    chk("refill drop_cnt", drop_cnt, 2);
    out_ready = 1'b1;
    commit(pc, 32'h00000013, 5'd5, 64'd0, 1'b0);
    out_ready = 1'b0;
    chk("full push+pop no drop", drop_cnt, 2);
    chk("full push+pop head", out_pc, 64'h302C);
    out_ready = 1'b1;
    n = 0;
    last = '0;
    while (out_valid && n < 20) begin
      last = out_pc;
      n++;
      cyc();
    end
    chk("refill drain count", 64'(n), 8);
    chk("refill drain last", last, pc);

    // Pc sequence checker.
    do_reset();
    commit(64'h1000, 32'h00000013, 5'd0, 64'd0, 1'b0);
    commit(64'h1010, 32'h00000013, 5'd0, 64'd0, 1'b0);
    chk("pcchk seq pc_err", pc_err, PCCHK);
    chk("pcchk seq err_pc", err_pc, PCCHK ? 64'h1010 : 64'h0);
    commit(64'h2000, 32'h00000013, 5'd0, 64'd0, 1'b0);
    chk("pcchk err_pc kept", err_pc, PCCHK ? 64'h1010 : 64'h0);

    do_reset();
    commit(64'h1000, 32'h00000063, 5'd0, 64'd0, 1'b0);
    commit(64'h1010, 32'h0000006F, 5'd0, 64'd0, 1'b0);
    chk("pcchk branch exempt", pc_err, 0);
    commit(64'h1012, 32'h00000013, 5'd0, 64'd0, 1'b0);
    chk("pcchk misaligned", pc_err, PCCHK);
    chk("pcchk misaligned pc", err_pc, PCCHK ? 64'h1012 : 64'h0);

    // Asynchronous reset with records queued.
    do_reset();
    commit(64'h5000, 32'h06300093, 5'd1, 64'd99, 1'b0);
    commit(64'h5004, 32'h00000013, 5'd0, 64'd0, 1'b0);
    commit(64'h5008, 32'h00000013, 5'd0, 64'd0, 1'b0);
    chk("pre-reset queued", out_valid, 1);
    chk("pre-reset cnt", commit_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst commit_cnt", commit_cnt, 0);
    chk("async rst out_pc", out_pc, 0);
    cyc();
    rst_n = 1'b1;
    rf_raddr = 5'd1;
    cyc();
    chk("post-reset x1", rf_rdata, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
